// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter: one FIFO per writeback source, round-robin
// pop on conflict, registered single write port towards the register file.

module regfile_wb_fifo #(
    parameter int unsigned W     = 37,
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_data,
    input  logic          pop,
    output logic [W-1:0]  head,
    output logic [CW-1:0] count
);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push;
    logic          pop_ok;

    // Ready looks only at stored occupancy, never at a same-cycle pop.
    assign in_ready = !rst && (count_q < CW'(DEPTH));
    assign push     = in_valid && in_ready;
    assign pop_ok   = pop && (count_q != '0);
    assign head     = mem_q[rptr_q];
    assign count    = count_q;

    always_comb begin
        mem_d   = mem_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (push) begin
            mem_d[wptr_q] = in_data;
            wptr_d        = wptr_q + PW'(1);
        end
        if (pop_ok) begin
            rptr_d = rptr_q + PW'(1);
        end
        case ({push, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q   <= '{default: '0};
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end
endmodule

module regfile_wb_arbiter #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned QDEPTH = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        a_valid,
    output logic                        a_ready,
    input  logic [ADDR_W-1:0]           a_addr,
    input  logic [DATA_W-1:0]           a_data,
    input  logic                        b_valid,
    output logic                        b_ready,
    input  logic [ADDR_W-1:0]           b_addr,
    input  logic [DATA_W-1:0]           b_data,
    output logic                        write_enable,
    output logic [ADDR_W-1:0]           write_addr,
    output logic [DATA_W-1:0]           write_data,
    output logic [$clog2(QDEPTH):0]     a_count,
    output logic [$clog2(QDEPTH):0]     b_count,
    output logic                        busy
);
    localparam int unsigned CW = $clog2(QDEPTH) + 1;
    localparam int unsigned EW = ADDR_W + DATA_W;

    typedef enum logic {RR_A = 1'b0, RR_B = 1'b1} rr_e;

    rr_e               rr_q, rr_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              busy_q, busy_d;
    logic              pop_a, pop_b;
    logic              a_ne, b_ne;
    logic              a_next_ne, b_next_ne;
    logic [EW-1:0]     a_head, b_head;

    regfile_wb_fifo #(.W(EW), .DEPTH(QDEPTH), .CW(CW)) u_fifo_a (
        .clk      (clk),
        .rst      (rst),
        .in_valid (a_valid),
        .in_ready (a_ready),
        .in_data  ({a_addr, a_data}),
        .pop      (pop_a),
        .head     (a_head),
        .count    (a_count)
    );

    regfile_wb_fifo #(.W(EW), .DEPTH(QDEPTH), .CW(CW)) u_fifo_b (
        .clk      (clk),
        .rst      (rst),
        .in_valid (b_valid),
        .in_ready (b_ready),
        .in_data  ({b_addr, b_data}),
        .pop      (pop_b),
        .head     (b_head),
        .count    (b_count)
    );

    assign a_ne = (a_count != '0);
    assign b_ne = (b_count != '0);

    // Pop selection, round-robin pointer (moves only on conflicts), write staging.
    always_comb begin
        pop_a   = 1'b0;
        pop_b   = 1'b0;
        rr_d    = rr_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        if (a_ne && b_ne) begin
            if (rr_q == RR_B) begin
                pop_b = 1'b1;
                rr_d  = RR_A;
            end else begin
                pop_a = 1'b1;
                rr_d  = RR_B;
            end
        end else if (a_ne) begin
            pop_a = 1'b1;
        end else if (b_ne) begin
            pop_b = 1'b1;
        end
        if (pop_a) begin
            we_d               = 1'b1;
            {waddr_d, wdata_d} = a_head;
        end else if (pop_b) begin
            we_d               = 1'b1;
            {waddr_d, wdata_d} = b_head;
        end
        a_next_ne = (a_valid && a_ready) || (a_count > CW'(pop_a));
        b_next_ne = (b_valid && b_ready) || (b_count > CW'(pop_b));
        busy_d    = we_d || a_next_ne || b_next_ne;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_q    <= RR_A;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            busy_q  <= 1'b0;
        end else begin
            rr_q    <= rr_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            busy_q  <= busy_d;
        end
    end

    assign write_enable = we_q;
    assign write_addr   = waddr_q;
    assign write_data   = wdata_q;
    assign busy         = busy_q;
endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 The block SHALL have the following parameters.
- DATA_W, 32: writeback data width.
- ADDR_W, 5: register address width (32 registers).
- QDEPTH, 2: entries per requester queue, power of two, at least 2.

REQ-002 The block SHALL have the following ports. Clock and reset come first. All inputs are sampled on the rising edge of clk.
- clk  in  1  single clock.
- rst  in  1  synchronous active-high reset.
- a_valid  in  1  source A (ALU writeback) offers an entry.
- a_ready  out  1  queue A can accept an entry.
- a_addr  in  ADDR_W  destination register of A.
- a_data  in  DATA_W  write value of A.
- b_valid  in  1  source B (load writeback) offers an entry.
- b_ready  out  1  queue B can accept an entry.
- b_addr  in  ADDR_W  destination register of B.
- b_data  in  DATA_W  write value of B.
- write_enable  out  1  drives the register-file write enable.
- write_addr  out  ADDR_W  drives the register-file write address.
- write_data  out  DATA_W  drives the register-file write data.
- a_count  out  $clog2(QDEPTH)+1  current occupancy of queue A.
- b_count  out  $clog2(QDEPTH)+1  current occupancy of queue B.
- busy  out  1  set when any queue is non-empty or write_enable is high.

Function
REQ-003 Each source SHALL own a FIFO of QDEPTH entries holding {addr, data}.
REQ-004 A push SHALL occur on a clock edge where x_valid and x_ready are both high.
REQ-005 x_ready SHALL equal (x_count < QDEPTH) and SHALL NOT depend on a pop in the same cycle.
REQ-006 x_valid high while x_ready is low SHALL be ignored; the source holds its entry.
REQ-007 Each cycle, the block SHALL select at most one non-empty queue to pop.
- Only A non-empty: pop A.
- Only B non-empty: pop B.
- Both non-empty: pop the queue not granted on the last two-way conflict (round-robin).
REQ-008 The round-robin pointer SHALL update only on cycles where both queues were non-empty.
REQ-009 After reset, the round-robin pointer SHALL favour A.
REQ-010 The popped entry SHALL appear on write_addr/write_data with write_enable=1 in the cycle after the pop edge. Outputs are registered; there is no combinational path from inputs.
REQ-011 Minimum latency SHALL be 2 edges: push at edge k, pop at edge k+1, write_enable visible after edge k+1.
REQ-012 An entry pushed at edge k SHALL NOT be popped at edge k; there is no bypass into an empty queue.
REQ-013 When no pop occurs, write_enable SHALL be 0. write_addr and write_data SHALL hold their last values.
REQ-014 A simultaneous push and pop on the same queue SHALL leave x_count unchanged and preserve FIFO order.
REQ-015 FIFO pointers SHALL wrap modulo QDEPTH. x_count SHALL never exceed QDEPTH nor underflow.
REQ-016 Within one source, write order SHALL equal push order.
REQ-017 No ordering SHALL be guaranteed between sources. The upstream pipeline owns same-address hazards across sources.
REQ-018 Sustained throughput SHALL be one write per cycle while any queue is non-empty.
REQ-019 Under continuous two-source contention, grants SHALL strictly alternate A,B,A,B.

Reset
REQ-020 On rst high at a clock edge, the block SHALL:
- clear both queues (a_count = b_count = 0) and discard pending entries;
- set write_enable, write_addr and write_data to 0;
- point round-robin at A.
REQ-021 While rst is high, a_ready and b_ready SHALL be 0, and pushes SHALL be ignored.
REQ-022 Reset asserted mid-operation SHALL take effect at that edge. No write SHALL issue in the following cycle.

Verification
REQ-023 Single write: push A {addr=3, data=0xDEADBEEF} at edge 1. Required: write_enable=1, write_addr=3, write_data=0xDEADBEEF after edge 2, and write_enable=0 after edge 3.
REQ-024 Contention: both queues pre-filled with 2 entries (A: r1,r2; B: r5,r6), no new pushes. Required: write order r1,r5,r2,r6; busy falls one cycle after the last write.
REQ-025 Full/backpressure: hold b_valid=1 with no pops possible (A queue also busy, B pointer losing). Required: b_ready=0 at b_count=2, and the held entry enters only after the first B pop.
REQ-026 Throughput: stream 8 A entries back-to-back with B idle. Required: 8 consecutive write_enable cycles, in order, with a_count never exceeding 2.
REQ-027 Reset mid-operation: both queues full, assert rst for one edge. Required: counts 0, write_enable 0 on the next cycle, and the first conflict after reset grants A.
